lock_code_entry: RTL

- Sequential front-end for the combinational 6-input Lock checker (inputs a..f, output z).
- Collects a 6-bit code entered one bit per keypress.
- Presents the code to the checker for a fixed settle window, then samples z.
- Manages the open window, failed-attempt counting and timed lockout.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/lock_timer.sv | 27 ++
 rtl/lock_code_entry.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the code-entry front-end
// of the six-input combination lock.
package lock_pkg;

    localparam int CODE_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PRESENT,
        OPEN,
        LOCKOUT
    } state_e;

    // The timer only ever holds window-1, so clog2(max) bits suffice.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the settle, open and lockout windows.
// Holds at zero until reloaded.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_code_entry.sv
// Collects a keyed code bit by bit, presents it to the lock checker,
// then runs the open window, failure count and timed lockout.
module lock_code_entry
    import lock_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int OPEN_CYC   = 8,
    parameter int MAX_FAIL   = 3,
    parameter int LOCK_CYC   = 16,
    localparam int FW        = $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic              key_bit,
    input  logic              key_clear,
    output logic [CODE_W-1:0] code,
    input  logic              z_in,
    output logic              unlocked,
    output logic              lockout,
    output logic              busy,
    output logic [FW-1:0]     fail_cnt
);

    localparam int TW  = timer_w(SETTLE_CYC, OPEN_CYC, LOCK_CYC);
    localparam int BW  = $clog2(CODE_W + 1);
    localparam int FW1 = FW + 1;

    state_e            state_q;
    logic [CODE_W-1:0] sr_q;
    logic [CODE_W-1:0] code_q;
    logic [BW-1:0]     bits_q;
    logic [FW-1:0]     fail_q;
    logic              unl_q;
    logic              lko_q;
    logic              busy_q;

    logic [CODE_W-1:0] sr_d;
    logic [BW-1:0]     bits_d;
    logic              entering;
    logic              full;
    logic              fail_lock;
    logic              done;
    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;

    always_comb begin
        entering  = (state_q == IDLE || state_q == COLLECT)
                    && key_valid && !key_clear;
        sr_d      = (state_q == IDLE) ? CODE_W'(key_bit)
                    : ((sr_q << 1) | CODE_W'(key_bit));
        bits_d    = ((state_q == IDLE) ? '0 : bits_q) + BW'(1);
        full      = entering && (bits_d == BW'(CODE_W));
        fail_lock = ({1'b0, fail_q} + FW1'(1)) >= FW1'(MAX_FAIL);
        done      = (state_q == PRESENT) && tmr_zero;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (1'b1)
            full: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(SETTLE_CYC - 1);
            end
            done && z_in: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(OPEN_CYC - 1);
            end
            done && !z_in && fail_lock: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(LOCK_CYC - 1);
            end
            default: ;
        endcase
    end

    lock_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            code_q  <= '0;
            bits_q  <= '0;
            fail_q  <= '0;
            unl_q   <= 1'b0;
            lko_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (key_clear) begin
                        sr_q    <= '0;
                        bits_q  <= '0;
                        state_q <= IDLE;
                    end else if (key_valid) begin
                        sr_q   <= sr_d;
                        bits_q <= bits_d;
                        if (full) begin
                            state_q <= PRESENT;
                            code_q  <= sr_d;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                PRESENT: begin
                    if (tmr_zero) begin
                        sr_q   <= '0;
                        bits_q <= '0;
                        code_q <= '0;
                        if (z_in) begin
                            state_q <= OPEN;
                            unl_q   <= 1'b1;
                            fail_q  <= '0;
                        end else if (fail_lock) begin
                            state_q <= LOCKOUT;
                            lko_q   <= 1'b1;
                            fail_q  <= FW'(MAX_FAIL);
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            fail_q  <= fail_q + FW'(1);
                        end
                    end
                end
                OPEN: begin
                    if (tmr_zero) begin
                        state_q <= IDLE;
                        unl_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (tmr_zero) begin
                        state_q <= IDLE;
                        lko_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        fail_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign code     = code_q;
    assign unlocked = unl_q;
    assign lockout  = lko_q;
    assign busy     = busy_q;
    assign fail_cnt = fail_q;

endmodule
